// File: rtl/cabac_ulow_pipe_if.sv
// Beat-level handshake bundle between the range-update stage, the low-update
// pipe and the bit-packer. The slave modport is the pipe's view of the bundle.
interface cabac_ulow_pipe_if #(
    parameter int unsigned BINS    = 5,
    parameter int unsigned LOW_W   = 9,
    parameter int unsigned SHIFT_W = 3,
    parameter int unsigned BUF_W   = 7
);
    localparam int unsigned NUM_W = 4;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_W-1:0]         in_number;
    logic                     in_end_slice;
    logic [BINS-1:0]          in_bypass;
    logic [BINS-1:0]          in_lpsmps;
    logic [BINS*SHIFT_W-1:0]  in_shift;
    logic [BINS*LOW_W-1:0]    in_r_rmps;

    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_W-1:0]         out_number;
    logic [BINS*SHIFT_W-1:0]  out_shift;
    logic [BINS-1:0]          out_overflow;
    logic [BINS*BUF_W-1:0]    out_buffer;

    modport slave (
        input  in_valid, in_number, in_end_slice, in_bypass, in_lpsmps,
               in_shift, in_r_rmps, out_ready,
        output in_ready, out_valid, out_number, out_shift, out_overflow,
               out_buffer
    );

    modport master (
        output in_valid, in_number, in_end_slice, in_bypass, in_lpsmps,
               in_shift, in_r_rmps, out_ready,
        input  in_ready, out_valid, out_number, out_shift, out_overflow,
               out_buffer
    );
endinterface

// File: rtl/cabac_ulow_pipe.sv
// CABAC low-register update stage: up to BINS bins per beat are chained
// through the running low value; each bin yields its carry and shifted-out
// bits. Results go through a 2-entry output FIFO, and an end-of-slice beat
// triggers a flush entry that drains the remaining low bits.
module cabac_ulow_pipe #(
    parameter int unsigned BINS    = 5,
    parameter int unsigned LOW_W   = 9,
    parameter int unsigned SHIFT_W = 3,
    parameter int unsigned BUF_W   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    cabac_ulow_pipe_if.slave    bus,
    output logic [31:0]         bin_count
);
    localparam int unsigned NUM_W    = 4;
    localparam int unsigned FL_LANES = (BINS < 2) ? 2 : BINS;
    localparam logic [NUM_W-1:0] BINS_N = NUM_W'(BINS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [LOW_W-1:0]        low_q;
    logic [1:0]              fifo_cnt;

    logic [NUM_W-1:0]        e_num   [2];
    logic [BINS*SHIFT_W-1:0] e_shift [2];
    logic [BINS-1:0]         e_ovf   [2];
    logic [BINS*BUF_W-1:0]   e_buf   [2];

    logic                    ready_c;
    logic                    accept_c;
    logic                    push_flush_c;
    logic                    push_c;
    logic                    pop_c;
    logic                    wr_idx_c;

    logic [NUM_W-1:0]        n_sat_c;
    logic [LOW_W-1:0]        low_after_c;
    logic [BINS*SHIFT_W-1:0] beat_shift_c;
    logic [BINS-1:0]         beat_ovf_c;
    logic [BINS*BUF_W-1:0]   beat_buf_c;

    logic [FL_LANES*SHIFT_W-1:0] fl_shift_c;
    logic [FL_LANES*BUF_W-1:0]   fl_buf_c;

    logic [NUM_W-1:0]        push_num_c;
    logic [BINS*SHIFT_W-1:0] push_shift_c;
    logic [BINS-1:0]         push_ovf_c;
    logic [BINS*BUF_W-1:0]   push_buf_c;

    assign n_sat_c       = (bus.in_number > BINS_N) ? BINS_N : bus.in_number;
    assign pop_c         = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = ready_c;

    assign bus.out_valid    = (fifo_cnt != 2'd0);
    assign bus.out_number   = e_num[0];
    assign bus.out_shift    = e_shift[0];
    assign bus.out_overflow = e_ovf[0];
    assign bus.out_buffer   = e_buf[0];

    // Per-bin add / carry / shift-out, chained through the active lanes.
    always_comb begin : lane_calc
        logic [LOW_W-1:0]   cur;
        logic [LOW_W:0]     sum;
        logic [SHIFT_W-1:0] s;
        cur          = low_q;
        sum          = '0;
        s            = '0;
        beat_shift_c = '0;
        beat_ovf_c   = '0;
        beat_buf_c   = '0;
        for (int k = 0; k < int'(BINS); k++) begin
            if (k < int'(n_sat_c)) begin
                sum = {1'b0, cur} + (bus.in_lpsmps[k] ?
                      {1'b0, bus.in_r_rmps[k*LOW_W +: LOW_W]} : '0);
                s   = bus.in_bypass[k] ? SHIFT_W'(1)
                                       : bus.in_shift[k*SHIFT_W +: SHIFT_W];
                beat_ovf_c[k]                      = sum[LOW_W];
                beat_shift_c[k*SHIFT_W +: SHIFT_W] = s;
                beat_buf_c[k*BUF_W +: BUF_W]       =
                    BUF_W'(sum[LOW_W-1:0] >> (LOW_W - int'(s)));
                cur = LOW_W'(sum[LOW_W-1:0] << s);
            end
        end
        low_after_c = cur;
    end

    // Flush entry: top BUF_W bits of low in lane 0, the remainder in lane 1.
    always_comb begin
        fl_shift_c = '0;
        fl_buf_c   = '0;
        fl_shift_c[0 +: SHIFT_W]       = SHIFT_W'(BUF_W);
        fl_shift_c[SHIFT_W +: SHIFT_W] = SHIFT_W'(LOW_W - BUF_W);
        fl_buf_c[0 +: BUF_W]           = low_q[LOW_W-1 -: BUF_W];
        fl_buf_c[BUF_W +: BUF_W]       = BUF_W'(low_q[LOW_W-BUF_W-1:0]);
    end

    // FIFO write payload: flush entry or the current beat's results.
    always_comb begin
        push_num_c   = n_sat_c;
        push_shift_c = beat_shift_c;
        push_ovf_c   = beat_ovf_c;
        push_buf_c   = beat_buf_c;
        if (push_flush_c) begin
            push_num_c   = NUM_W'(2);
            push_shift_c = fl_shift_c[BINS*SHIFT_W-1:0];
            push_ovf_c   = '0;
            push_buf_c   = fl_buf_c[BINS*BUF_W-1:0];
        end
    end

    assign push_c   = push_flush_c || (accept_c && (n_sat_c != '0));
    assign wr_idx_c = ((fifo_cnt - {1'b0, pop_c}) != 2'd0);

    // Slice FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else if (clr) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Slice FSM next state, ready and flush push.
    always_comb begin
        state_d      = state_q;
        ready_c      = 1'b0;
        accept_c     = 1'b0;
        push_flush_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                ready_c  = (fifo_cnt < 2'd2);
                accept_c = bus.in_valid && ready_c;
                if (accept_c && bus.in_end_slice) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((fifo_cnt < 2'd2) || pop_c) begin
                    push_flush_c = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Running low register and accepted-bin counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_q     <= '0;
            bin_count <= '0;
        end else if (clr) begin
            low_q     <= '0;
            bin_count <= '0;
        end else begin
            if (accept_c) begin
                low_q     <= low_after_c;
                bin_count <= bin_count + 32'(n_sat_c);
            end else if (push_flush_c) begin
                low_q <= '0;
            end
        end
    end

    // Two-entry shift FIFO; entry 0 is always the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                e_num[i]   <= '0;
                e_shift[i] <= '0;
                e_ovf[i]   <= '0;
                e_buf[i]   <= '0;
            end
        end else if (clr) begin
            fifo_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                e_num[i]   <= '0;
                e_shift[i] <= '0;
                e_ovf[i]   <= '0;
                e_buf[i]   <= '0;
            end
        end else begin
            if (pop_c && (fifo_cnt == 2'd2)) begin
                e_num[0]   <= e_num[1];
                e_shift[0] <= e_shift[1];
                e_ovf[0]   <= e_ovf[1];
                e_buf[0]   <= e_buf[1];
            end
            if (push_c) begin
                e_num[wr_idx_c]   <= push_num_c;
                e_shift[wr_idx_c] <= push_shift_c;
                e_ovf[wr_idx_c]   <= push_ovf_c;
                e_buf[wr_idx_c]   <= push_buf_c;
            end
            fifo_cnt <= 2'(fifo_cnt - {1'b0, pop_c} + {1'b0, push_c});
        end
    end
endmodule

// File: tb/tb_cabac_ulow_pipe.sv
// Directed bench for cabac_ulow_pipe with hand-computed expected values.
`timescale 1ns/1ps
module tb_cabac_ulow_pipe;
    localparam int unsigned BINS    = 5;
    localparam int unsigned LOW_W   = 9;
    localparam int unsigned SHIFT_W = 3;
    localparam int unsigned BUF_W   = 7;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] bin_count;

    int tests_run;
    int tests_failed;

    cabac_ulow_pipe_if #(.BINS(BINS), .LOW_W(LOW_W), .SHIFT_W(SHIFT_W),
                         .BUF_W(BUF_W)) bus ();

    cabac_ulow_pipe #(.BINS(BINS), .LOW_W(LOW_W), .SHIFT_W(SHIFT_W),
                      .BUF_W(BUF_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .bin_count (bin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.in_valid     = 1'b0;
        bus.in_number    = '0;
        bus.in_end_slice = 1'b0;
        bus.in_bypass    = '0;
        bus.in_lpsmps    = '0;
        bus.in_shift     = '0;
        bus.in_r_rmps    = '0;
    endtask

    task automatic set_lane(input int k, input logic byp, input logic lps,
                            input int sh, input int r);
        bus.in_bypass[k]                  = byp;
        bus.in_lpsmps[k]                  = lps;
        bus.in_shift[k*SHIFT_W +: SHIFT_W] = SHIFT_W'(sh);
        bus.in_r_rmps[k*LOW_W +: LOW_W]    = LOW_W'(r);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        clr = 1'b0;
        bus.out_ready = 1'b1;
        clear_lanes();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_bin_count", 64'(bin_count), 64'd0);
        check("rst_out_number", 64'(bus.out_number), 64'd0);
        check("rst_out_buffer", 64'(bus.out_buffer), 64'd0);

        // Single regular LPS bin: 0 + 0x1F0, shift 2 -> buf 3, low 0x1C0
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd1;
        set_lane(0, 1'b0, 1'b1, 2, 'h1F0);
        tick();
        clear_lanes();
        check("b1_valid", 64'(bus.out_valid), 64'd1);
        check("b1_number", 64'(bus.out_number), 64'd1);
        check("b1_ovf", 64'(bus.out_overflow), 64'd0);
        check("b1_buf", 64'(bus.out_buffer), 64'h3);
        check("b1_shift", 64'(bus.out_shift), 64'h2);
        tick();
        check("b1_drained", 64'(bus.out_valid), 64'd0);

        // Two bins from a cleared low; lane 1 carries out
        do_clr();
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd2;
        set_lane(0, 1'b0, 1'b1, 2, 'h1F0);
        set_lane(1, 1'b0, 1'b1, 0, 'h100);
        tick();
        clear_lanes();
        check("b2_number", 64'(bus.out_number), 64'd2);
        check("b2_ovf", 64'(bus.out_overflow), 64'b00010);
        check("b2_buf", 64'(bus.out_buffer), 64'h3);
        check("b2_shift", 64'(bus.out_shift), 64'h2);
        check("b2_bin_count", 64'(bin_count), 64'd2);
        check("b2_in_ready", 64'(bus.in_ready), 64'd1);

        // Empty end-of-slice beat, low = 0x0C0 -> flush 0x30 / 0
        bus.in_valid     = 1'b1;
        bus.in_number    = 4'd0;
        bus.in_end_slice = 1'b1;
        tick();
        clear_lanes();
        check("es_no_data", 64'(bus.out_valid), 64'd0);
        check("es_ready_lo", 64'(bus.in_ready), 64'd0);
        tick();
        check("fl_valid", 64'(bus.out_valid), 64'd1);
        check("fl_number", 64'(bus.out_number), 64'd2);
        check("fl_shift", 64'(bus.out_shift), 64'h17);
        check("fl_buf", 64'(bus.out_buffer), 64'h30);
        check("fl_ovf", 64'(bus.out_overflow), 64'd0);
        check("fl_bin_count", 64'(bin_count), 64'd2);
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd1;
        tick();
        tick();
        check("done_ready", 64'(bus.in_ready), 64'd0);
        check("done_empty", 64'(bus.out_valid), 64'd0);
        check("done_no_count", 64'(bin_count), 64'd2);
        clear_lanes();
        do_clr();
        check("clr_ready", 64'(bus.in_ready), 64'd1);
        check("clr_bin_count", 64'(bin_count), 64'd0);

        // Bypass lane ignores in_shift: low 0x100 + 0x180 -> carry, low 0x100
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd2;
        set_lane(0, 1'b0, 1'b1, 0, 'h100);
        set_lane(1, 1'b1, 1'b1, 5, 'h180);
        tick();
        clear_lanes();
        check("byp_ovf", 64'(bus.out_overflow), 64'b00010);
        check("byp_shift", 64'(bus.out_shift), 64'h08);
        check("byp_buf", 64'(bus.out_buffer), 64'h0);
        bus.in_valid     = 1'b1;
        bus.in_end_slice = 1'b1;
        tick();
        clear_lanes();
        tick();
        check("byp_fl_buf", 64'(bus.out_buffer), 64'h40);
        check("byp_fl_number", 64'(bus.out_number), 64'd2);
        do_clr();

        // in_number above BINS saturates
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd9;
        tick();
        clear_lanes();
        check("sat_number", 64'(bus.out_number), 64'd5);
        check("sat_bin_count", 64'(bin_count), 64'd5);
        tick();
        do_clr();

        // Back-pressure: two beats fill the FIFO, third waits
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd1;
        tick();
        bus.in_number = 4'd2;
        tick();
        bus.in_number = 4'd3;
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head_stable", 64'(bus.out_number), 64'd1);
        check("bp_count2", 64'(bin_count), 64'd3);
        bus.out_ready = 1'b1;
        tick();
        check("bp_drain1", 64'(bus.out_number), 64'd2);
        check("bp_ready_back", 64'(bus.in_ready), 64'd1);
        check("bp_not_yet", 64'(bin_count), 64'd3);
        tick();
        clear_lanes();
        check("bp_third", 64'(bus.out_number), 64'd3);
        check("bp_count3", 64'(bin_count), 64'd6);
        tick();
        check("bp_empty", 64'(bus.out_valid), 64'd0);
        do_clr();

        // Throughput: back-to-back beats with out_ready high
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_number = 4'(i);
            tick();
            check("tp_ready", 64'(bus.in_ready), 64'd1);
            check("tp_number", 64'(bus.out_number), 64'(i));
        end
        clear_lanes();
        tick();
        do_clr();

        // Async reset with full FIFO and a pending flush
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_number = 4'd1;
        set_lane(0, 1'b0, 1'b1, 0, 'h0AA);
        tick();
        bus.in_end_slice = 1'b1;
        tick();
        clear_lanes();
        tick();
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_buf", 64'(bus.out_buffer), 64'd0);
        check("rst_mid_count", 64'(bin_count), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        tick();
        tick();
        check("post_rst_no_flush", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
